// File: rtl/cpu_irq_ctrl.sv
// rtl/cpu_irq_ctrl.sv - parametrised edge/level, maskable/NMI interrupt controller for a 6502-family core
module cpu_irq_ctrl #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(1),
    parameter logic [NUM_SRC-1:0] NMI_MASK  = NUM_SRC'(1),
    parameter logic [15:0]        VEC_BASE  = 16'hFFF0,
    parameter logic [15:0]        RESET_VEC = 16'hFFFC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               i_flag,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               poll,
    input  logic               vec_fetch,
    input  logic               vec_hi,
    output logic               take,
    output logic               is_reset,
    output logic [2:0]         src_id,
    output logic [15:0]        vec_addr,
    output logic [NUM_SRC-1:0] pending
);

    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] ack_mask;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [2:0]         win_id;
    logic               ack;
    logic               ack_done;

    // Edge detection is frozen during a vector fetch; prev also holds, so an
    // edge arriving mid-fetch is seen on the first cycle after the fetch.
    assign rise = irq_in & ~prev & EDGE_MASK & {NUM_SRC{~vec_fetch}};
    assign elig = pending & (NMI_MASK | (enable & {NUM_SRC{~i_flag}}));

    // ack_done limits the acknowledge to one low-byte fetch per taken
    // interrupt, so a repeated fetch cannot eat a fresh edge on the same source.
    assign ack = vec_fetch & ~vec_hi & take & ~ack_done;

    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) win_id = 3'(i);
        end
    end

    always_comb begin
        ack_mask = '0;
        if (ack) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (3'(i) == src_id) ack_mask[i] = 1'b1;
            end
        end
        pending_nxt = (((pending | rise) & ~ack_mask) & EDGE_MASK) | (irq_in & ~EDGE_MASK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            take     <= 1'b1;
            is_reset <= 1'b1;
            src_id   <= '0;
            pending  <= '0;
            prev     <= '0;
            enable   <= '1;
            ack_done <= 1'b0;
        end else if (ce) begin
            pending <= pending_nxt;
            if (!vec_fetch) prev <= irq_in;
            if (en_we) enable <= en_wdata;
            if (ack) ack_done <= 1'b1;
            // poll opens a new interrupt decision; it wins over a same-cycle ack for ack_done
            if (poll) begin
                take     <= |elig;
                is_reset <= 1'b0;
                ack_done <= 1'b0;
                if (|elig) src_id <= win_id;
            end
        end
    end

    assign vec_addr = (is_reset ? RESET_VEC : VEC_BASE + {12'b0, src_id, 1'b0}) + {15'b0, vec_hi};

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// tb/tb_cpu_irq_ctrl.sv - self-checking bench for cpu_irq_ctrl with directed steps and a random reference-model run
module tb_cpu_irq_ctrl;

    localparam int          N  = 4;
    localparam logic [3:0]  EM = 4'b0001;
    localparam logic [3:0]  NM = 4'b0001;
    localparam logic [15:0] VB = 16'hFFF0;
    localparam logic [15:0] RV = 16'hFFFC;

    logic          clk = 1'b0;
    logic          reset, ce, i_flag, en_we, poll, vec_fetch, vec_hi;
    logic [N-1:0]  irq_in, en_wdata;
    logic          take, is_reset;
    logic [2:0]    src_id;
    logic [15:0]   vec_addr;
    logic [N-1:0]  pending;

    int total = 0;
    int bad   = 0;

    // reference state, kept as plain per-source flags
    bit m_take, m_rst, m_acked;
    int m_src;
    bit m_pend [N];
    bit m_prev [N];
    bit m_en   [N];

    always #5 clk = ~clk;

    cpu_irq_ctrl #(
        .NUM_SRC(N), .EDGE_MASK(EM), .NMI_MASK(NM), .VEC_BASE(VB), .RESET_VEC(RV)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .irq_in(irq_in), .i_flag(i_flag),
        .en_we(en_we), .en_wdata(en_wdata), .poll(poll), .vec_fetch(vec_fetch),
        .vec_hi(vec_hi), .take(take), .is_reset(is_reset), .src_id(src_id),
        .vec_addr(vec_addr), .pending(pending)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_vec();
        logic [15:0] base;
        base = m_rst ? RV : VB + 16'(2 * m_src);
        return base + 16'(vec_hi);
    endfunction

    function automatic logic [15:0] m_pend_word();
        logic [15:0] w;
        w = '0;
        for (int i = 0; i < N; i++) w[i] = m_pend[i];
        return w;
    endfunction

    task automatic model_step();
        int winner;
        bit do_ack;
        int ack_src;
        winner = -1;
        if (reset) begin
            m_take = 1; m_rst = 1; m_src = 0; m_acked = 0;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0; m_prev[i] = 0; m_en[i] = 1;
            end
            return;
        end
        if (!ce) return;
        for (int i = 0; i < N; i++)
            if (winner < 0 && m_pend[i] && (NM[i] || (m_en[i] && !i_flag))) winner = i;
        do_ack  = vec_fetch && !vec_hi && m_take && !m_acked;
        ack_src = m_src;
        for (int i = 0; i < N; i++) begin
            if (EM[i]) begin
                if (!vec_fetch && irq_in[i] && !m_prev[i]) m_pend[i] = 1;
                if (do_ack && ack_src == i) m_pend[i] = 0;
                if (!vec_fetch) m_prev[i] = irq_in[i];
            end else begin
                m_pend[i] = irq_in[i];
                if (!vec_fetch) m_prev[i] = irq_in[i];
            end
            if (en_we) m_en[i] = en_wdata[i];
        end
        if (do_ack) m_acked = 1;
        if (poll) begin
            m_take  = (winner >= 0);
            m_rst   = 0;
            m_acked = 0;
            if (winner >= 0) m_src = winner;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".take"},    16'(take),     16'(m_take));
        chk({tag, ".is_reset"}, 16'(is_reset), 16'(m_rst));
        chk({tag, ".src_id"},  16'(src_id),   16'(m_src));
        chk({tag, ".pending"}, 16'(pending),  m_pend_word());
        chk({tag, ".vec_addr"}, vec_addr,     m_vec());
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        reset = 1; ce = 1; irq_in = '0; i_flag = 1; en_we = 0; en_wdata = '0;
        poll = 0; vec_fetch = 0; vec_hi = 0;

        // 1: reset, release, poll with no requests
        tick("t1_rst");
        chk("t1_take", 16'(take), 16'd1);
        chk("t1_isrst", 16'(is_reset), 16'd1);
        chk("t1_src", 16'(src_id), 16'd0);
        chk("t1_pend", 16'(pending), 16'd0);
        chk("t1_vlo", vec_addr, 16'hFFFC);
        vec_hi = 1; #1;
        chk("t1_vhi", vec_addr, 16'hFFFD);
        vec_hi = 0; reset = 0; poll = 1;
        tick("t1_poll");
        chk("t1_take_after", 16'(take), 16'd0);
        chk("t1_isrst_after", 16'(is_reset), 16'd0);

        // 2: NMI pulse on source 0 with I set
        poll = 0; irq_in = 4'b0001;
        tick("t2_rise");
        chk("t2_pend_set", 16'(pending[0]), 16'd1);
        irq_in = '0; poll = 1;
        tick("t2_poll");
        chk("t2_take", 16'(take), 16'd1);
        chk("t2_src", 16'(src_id), 16'd0);
        poll = 0; vec_fetch = 1; vec_hi = 0; #1;
        chk("t2_vlo", vec_addr, 16'hFFF0);
        tick("t2_lo");
        chk("t2_pend_clr", 16'(pending[0]), 16'd0);
        vec_hi = 1; #1;
        chk("t2_vhi", vec_addr, 16'hFFF1);
        tick("t2_hi");
        vec_fetch = 0; vec_hi = 0;

        // 3: level sources 3:2 held, I clear then set
        i_flag = 0; irq_in = 4'b1100;
        tick("t3_lvl");
        poll = 1;
        tick("t3_poll");
        chk("t3_take", 16'(take), 16'd1);
        chk("t3_src", 16'(src_id), 16'd2);
        vec_fetch = 1; #1;
        chk("t3_vlo", vec_addr, 16'hFFF4);
        vec_fetch = 0; i_flag = 1; poll = 1;
        tick("t3_masked");
        chk("t3_take_masked", 16'(take), 16'd0);
        chk("t3_pend_kept", 16'(pending[3:2]), 16'd3);

        // 4: edge during a vector fetch is deferred, not lost
        poll = 0; irq_in = '0; vec_fetch = 1;
        tick("t4_f0");
        irq_in = 4'b0001;
        tick("t4_f1");
        chk("t4_pend_hold1", 16'(pending[0]), 16'd0);
        tick("t4_f2");
        chk("t4_pend_hold2", 16'(pending[0]), 16'd0);
        vec_fetch = 0;
        tick("t4_after");
        chk("t4_pend_set", 16'(pending[0]), 16'd1);
        poll = 1;
        tick("t4_poll");
        chk("t4_take", 16'(take), 16'd1);
        chk("t4_src", 16'(src_id), 16'd0);
        poll = 0; vec_fetch = 1; vec_hi = 0;
        tick("t4_ack");
        vec_fetch = 0; irq_in = '0;
        tick("t4_idle");

        // 5: masked by the enable register, then ce=0 freezes everything
        en_we = 1; en_wdata = 4'b0111;
        tick("t5_en");
        en_we = 0; irq_in = 4'b1000; i_flag = 0;
        tick("t5_lvl");
        poll = 1;
        tick("t5_poll");
        chk("t5_take", 16'(take), 16'd0);
        chk("t5_pend", 16'(pending), 16'h8);
        ce = 0; poll = 0; irq_in = '0;
        for (int k = 0; k < 5; k++) begin
            poll = (k == 2);
            tick("t5_ce0");
            chk("t5_ce0_take", 16'(take), 16'd0);
            chk("t5_ce0_pend", 16'(pending), 16'h8);
        end
        ce = 1; poll = 0;

        // 6: reset during the high-byte fetch of source 2
        en_we = 1; en_wdata = 4'b1111; irq_in = 4'b0100; i_flag = 0;
        tick("t6_en");
        en_we = 0; poll = 1;
        tick("t6_poll");
        chk("t6_src", 16'(src_id), 16'd2);
        poll = 0; vec_fetch = 1; vec_hi = 0;
        tick("t6_lo");
        vec_hi = 1; reset = 1;
        tick("t6_rst");
        reset = 0; vec_fetch = 0; vec_hi = 0; #1;
        chk("t6_take", 16'(take), 16'd1);
        chk("t6_isrst", 16'(is_reset), 16'd1);
        chk("t6_pend", 16'(pending), 16'd0);
        chk("t6_vec", vec_addr, 16'hFFFC);

        // random run against the reference model
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 99) == 0);
            ce        = ($urandom_range(0, 7) != 0);
            irq_in    = N'($urandom);
            i_flag    = 1'($urandom);
            en_we     = ($urandom_range(0, 15) == 0);
            en_wdata  = N'($urandom);
            poll      = ($urandom_range(0, 3) == 0);
            vec_fetch = ($urandom_range(0, 2) == 0);
            vec_hi    = 1'($urandom);
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
